// File: rtl/gbuf_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : gbuf_port_arbiter_if
// Purpose  : Bundles the two requester channels (request + registered read
//            response) and the single-port global buffer pins that the
//            gbuf_port_arbiter sits between.
// Ports    : rq{0,1}_*  request channel (valid/ready/we/addr/wdata)
//            rs{0,1}_*  read response channel (valid/rdata)
//            bram_*     buffer pins (en/wr_en/index/wdata driven, rdata back)
// Modports : slave  - arbiter side
//            master - requester + buffer side (environment)
// Revision : 1.0 - initial release
// ============================================================================
interface gbuf_port_arbiter_if #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32
);
  logic                 rq0_valid;
  logic                 rq0_ready;
  logic                 rq0_we;
  logic [ADDR_BITS-1:0] rq0_addr;
  logic [DATA_BITS-1:0] rq0_wdata;
  logic                 rs0_valid;
  logic [DATA_BITS-1:0] rs0_rdata;

  logic                 rq1_valid;
  logic                 rq1_ready;
  logic                 rq1_we;
  logic [ADDR_BITS-1:0] rq1_addr;
  logic [DATA_BITS-1:0] rq1_wdata;
  logic                 rs1_valid;
  logic [DATA_BITS-1:0] rs1_rdata;

  logic                 bram_en;
  logic                 bram_wr_en;
  logic [ADDR_BITS-1:0] bram_index;
  logic [DATA_BITS-1:0] bram_wdata;
  logic [DATA_BITS-1:0] bram_rdata;

  modport slave (
    input  rq0_valid, rq0_we, rq0_addr, rq0_wdata,
    output rq0_ready, rs0_valid, rs0_rdata,
    input  rq1_valid, rq1_we, rq1_addr, rq1_wdata,
    output rq1_ready, rs1_valid, rs1_rdata,
    output bram_en, bram_wr_en, bram_index, bram_wdata,
    input  bram_rdata
  );

  modport master (
    output rq0_valid, rq0_we, rq0_addr, rq0_wdata,
    input  rq0_ready, rs0_valid, rs0_rdata,
    output rq1_valid, rq1_we, rq1_addr, rq1_wdata,
    input  rq1_ready, rs1_valid, rs1_rdata,
    input  bram_en, bram_wr_en, bram_index, bram_wdata,
    output bram_rdata
  );
endinterface
`default_nettype wire

// File: rtl/gbuf_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gbuf_port_arbiter
// Purpose  : Shares one single-port global buffer between the host/CFU
//            load-store path (port 0) and the compute-array operand fetch
//            path (port 1). Round-robin with a bounded burst so a streaming
//            port cannot starve the other. Read data returns one cycle after
//            acceptance on a registered response channel.
// Ports    : clk   - clock, rising edge
//            rst_n - synchronous active-low reset
//            bus   - gbuf_port_arbiter_if.slave (request, response and
//                    buffer pins)
// Revision : 1.0 - initial release
// ============================================================================
module gbuf_port_arbiter #(
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32,
  parameter int BURST_MAX = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  gbuf_port_arbiter_if.slave  bus
);

  localparam int c_CNT_BITS = $clog2(BURST_MAX + 1);
  localparam logic [c_CNT_BITS-1:0] c_BURST_MAX = c_CNT_BITS'(BURST_MAX);
  localparam logic [c_CNT_BITS-1:0] c_CNT_ONE   = c_CNT_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_owner;
  logic                  w_owner_nxt;
  logic [c_CNT_BITS-1:0] r_burst_cnt;
  logic [c_CNT_BITS-1:0] w_burst_cnt_nxt;

  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_any_grant;
  logic                  w_wr_en;
  logic [ADDR_BITS-1:0]  w_index;
  logic [DATA_BITS-1:0]  w_wdata;

  logic                  r_rs0_valid;
  logic [DATA_BITS-1:0]  r_rs0_rdata;
  logic                  r_rs1_valid;
  logic [DATA_BITS-1:0]  r_rs1_rdata;

  // --------------------------------------------------------------------------
  // Grant decision and next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant0        = 1'b0;
    w_grant1        = 1'b0;
    w_state_nxt     = ST_IDLE;
    w_owner_nxt     = r_owner;
    w_burst_cnt_nxt = '0;

    // Grants are suppressed during reset so nothing reaches the buffer.
    if (rst_n) begin
      if (bus.rq0_valid && !bus.rq1_valid) begin
        w_grant0 = 1'b1;
      end else if (bus.rq1_valid && !bus.rq0_valid) begin
        w_grant1 = 1'b1;
      end else if (bus.rq0_valid && bus.rq1_valid) begin
        case (r_state)
          ST_OWN0: begin
            if (r_burst_cnt < c_BURST_MAX) w_grant0 = 1'b1;
            else                           w_grant1 = 1'b1;
          end
          ST_OWN1: begin
            if (r_burst_cnt < c_BURST_MAX) w_grant1 = 1'b1;
            else                           w_grant0 = 1'b1;
          end
          default: begin
            // Fresh contention: the port that did not own last wins.
            if (r_owner) w_grant0 = 1'b1;
            else         w_grant1 = 1'b1;
          end
        endcase
      end
    end

    if (w_grant0 || w_grant1) begin
      // w_grant1 doubles as the grantee's port number.
      if (w_grant1 == r_owner) begin
        w_burst_cnt_nxt = (r_burst_cnt >= c_BURST_MAX) ? c_BURST_MAX
                                                       : r_burst_cnt + c_CNT_ONE;
      end else begin
        w_burst_cnt_nxt = c_CNT_ONE;
      end
      w_owner_nxt = w_grant1;
      w_state_nxt = w_grant1 ? ST_OWN1 : ST_OWN0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= 1'b1;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Buffer drive: steered from the granted port, zero when nothing granted
  // --------------------------------------------------------------------------
  always_comb begin
    w_wr_en = 1'b0;
    w_index = '0;
    w_wdata = '0;
    if (w_grant0) begin
      w_wr_en = bus.rq0_we;
      w_index = bus.rq0_addr;
      w_wdata = bus.rq0_wdata;
    end else if (w_grant1) begin
      w_wr_en = bus.rq1_we;
      w_index = bus.rq1_addr;
      w_wdata = bus.rq1_wdata;
    end
  end

  assign w_any_grant    = w_grant0 | w_grant1;
  assign bus.rq0_ready  = w_grant0;
  assign bus.rq1_ready  = w_grant1;
  assign bus.bram_en    = w_any_grant;
  assign bus.bram_wr_en = w_wr_en;
  assign bus.bram_index = w_index;
  assign bus.bram_wdata = w_wdata;

  // --------------------------------------------------------------------------
  // Read responses: capture buffer data at the granted edge; one-cycle valid
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rs0_valid <= 1'b0;
      r_rs0_rdata <= '0;
      r_rs1_valid <= 1'b0;
      r_rs1_rdata <= '0;
    end else begin
      r_rs0_valid <= w_grant0 & ~bus.rq0_we;
      r_rs1_valid <= w_grant1 & ~bus.rq1_we;
      if (w_grant0 && !bus.rq0_we) r_rs0_rdata <= bus.bram_rdata;
      if (w_grant1 && !bus.rq1_we) r_rs1_rdata <= bus.bram_rdata;
    end
  end

  assign bus.rs0_valid = r_rs0_valid;
  assign bus.rs0_rdata = r_rs0_rdata;
  assign bus.rs1_valid = r_rs1_valid;
  assign bus.rs1_rdata = r_rs1_rdata;

endmodule
`default_nettype wire

// File: doc/gbuf_port_arbiter.md
Name: gbuf_port_arbiter

Overview:
- Shares one single-port global buffer between two requesters.
  - Port 0: host/CFU load and store path.
  - Port 1: compute-array operand fetch path.
- Drives the buffer's en, wr_en, index and data_in pins, and returns read data on a registered response channel.
- Uses round-robin arbitration with a bounded burst length, so a streaming requester cannot starve the other.

Parameters:
ADDR_BITS, 12, buffer address width (2^ADDR_BITS entries)
DATA_BITS, 32, buffer word width
BURST_MAX, 4, max consecutive grants to one port while the other port waits (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; synchronous, active-low
rq0_valid  in  1  port 0 request present
rq0_ready  out  1  port 0 request accepted this cycle (comb)
rq0_we  in  1  port 0: 1 = write, 0 = read
rq0_addr  in  ADDR_BITS  port 0 address
rq0_wdata  in  DATA_BITS  port 0 write data
rs0_valid  out  1  port 0 read response valid (registered)
rs0_rdata  out  DATA_BITS  port 0 read data (registered)
rq1_valid, rq1_ready, rq1_we, rq1_addr, rq1_wdata, rs1_valid, rs1_rdata  same as port 0, for port 1
bram_en  out  1  buffer enable (comb)
bram_wr_en  out  1  buffer write enable (comb)
bram_index  out  ADDR_BITS  buffer address (comb)
bram_wdata  out  DATA_BITS  buffer write data (comb)
bram_rdata  in  DATA_BITS  buffer read data (combinational from index while en=1)

Behaviour:
- Clock is clk. Reset is rst_n: synchronous, active-low.
- Reset values:
  - state IDLE, owner=1 (so port 0 wins the first tie), burst_cnt=0.
  - rs0_valid=rs1_valid=0, rs0_rdata=rs1_rdata=0.
- While rst_n=0, bram_en, bram_wr_en, rq0_ready and rq1_ready are forced to 0. No write may reach the buffer during reset.
- States:
  - IDLE: no grant last cycle.
  - OWN0 / OWN1: port 0 / port 1 was granted last cycle.
- Grant decision (combinational, at most one grant per cycle):
  - Only one valid: that port is granted.
  - Both valid, state IDLE: grant the port != owner.
  - Both valid, state OWNx: grant x if burst_cnt < BURST_MAX; otherwise grant the other port.
  - Neither valid: no grant.
- rqN_ready = grantN. A request transfers when valid & ready. Requesters hold we/addr/wdata stable until ready.
- Buffer drive:
  - bram_en = grant0 | grant1.
  - bram_wr_en = granted port's we.
  - bram_index and bram_wdata = granted port's fields.
  - With no grant, en=0 and index/wdata=0.
- State update on each rising edge:
  - Grant to the current owner: burst_cnt <= sat(burst_cnt+1, BURST_MAX).
  - Grant to the other port: owner <= grantee, burst_cnt <= 1, state <= OWNgrantee.
  - No grant: state <= IDLE, burst_cnt <= 0, owner unchanged.
- Writes complete at the granted edge. No response is issued for a write.
- Reads:
  - bram_rdata is captured into rsN_rdata at the granted edge, and rsN_valid=1 for exactly the next cycle.
  - Latency is 1 cycle from acceptance to response.
  - Back-to-back reads give back-to-back responses.
  - rsN_rdata holds its value when rsN_valid=0.
- No response backpressure: requesters must accept rsN_valid whenever it is asserted.
- Read-after-write to the same address on consecutive cycles (either port) returns the new data, because the write lands at edge N and the read samples at edge N+1.
- BURST_MAX=1 gives strict alternation under contention.
- Reset mid-operation: any pending rs*_valid is cleared at the reset edge, and a request granted in the reset cycle is dropped. The requester must re-issue it.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with rq0_valid=1, rq0_we=1 -> bram_en=0, rq0_ready=0, addr 5 unchanged on a later read; all outputs 0 after release until a request arrives.
- Single-port write then read: port 0 writes 0xDEADBEEF to addr 0x010, then reads 0x010 the next cycle -> ready=1 both cycles; rs0_valid=1 one cycle after the read, rs0_rdata=0xDEADBEEF.
- Contention, BURST_MAX=4: both ports issue continuous reads from cycle 0 -> grant order 0,0,0,0,1,1,1,1,0…; each port's responses follow its grants by 1 cycle with the correct data.
- Tie from IDLE: both ports request in the same cycle after reset -> port 0 granted. Go idle 1 cycle, both request again -> port 1 granted first (owner=0 so far, so the other port wins).
- Cross-port RAW: port 0 writes 0x00000055 to addr 3 at cycle N, port 1 reads addr 3 at N+1 -> rs1_rdata=0x00000055 at N+2.
- Reset mid-burst: assert rst_n=0 while port 1 holds a granted read -> rs1_valid=0 after the edge, bram_en=0 during reset. After release, port 0 wins the first tie.
